// File: rtl/booth_ctrl.sv
// Control FSM for a radix-2 Booth multiplier: sequences load, WIDTH evaluate/shift
// iterations and a one-cycle done pulse for an external {A,Q,Q(-1)} datapath.
module booth_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          q0,
    input  logic          qm1,
    output logic          ld_m,
    output logic          ld_q,
    output logic          clr_a,
    output logic          clr_qm1,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    // Handshake: start is a level sampled only while IDLE; done is a single-cycle
    // pulse; busy covers LOAD through the last SHIFT. Nothing is queued.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_next   = CW'(WIDTH);
                state_next = EVAL;
            end
            EVAL: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                // Saturating decrement; a zero count here would mean corrupted state.
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end
                state_next = (cnt <= CW'(1)) ? DONE : EVAL;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ld_m    = 1'b0;
        ld_q    = 1'b0;
        clr_a   = 1'b0;
        clr_qm1 = 1'b0;
        add_en  = 1'b0;
        sub_en  = 1'b0;
        shift   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            LOAD: begin
                ld_m    = 1'b1;
                ld_q    = 1'b1;
                clr_a   = 1'b1;
                clr_qm1 = 1'b1;
                busy    = 1'b1;
            end
            EVAL: begin
                // Booth pair {Q0,Q-1}: 01 adds M, 10 subtracts M, 00/11 idle.
                busy   = 1'b1;
                add_en = ~q0 & qm1;
                sub_en = q0 & ~qm1;
            end
            SHIFT: begin
                busy  = 1'b1;
                shift = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    a_add_sub_exclusive : assert property (@(posedge clk) !(add_en && sub_en));
    a_arith_only_in_eval : assert property (
        @(posedge clk) disable iff (clr) (add_en || sub_en) |-> (state == EVAL));
    a_cnt_no_wrap : assert property (
        @(posedge clk) disable iff (clr) (state == SHIFT) |-> (cnt != '0));

endmodule
